// File: rtl/rv_mc_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller.
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } mc_state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps alu_op and funct fields onto the ALU operation code.
module mc_alu_decoder
    import rv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // funct7[5] only means sub for R-type; addi ignores it
                    3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing the shared ALU, unified memory and register
// file of the multi-cycle RV32I core.
module multicycle_controller
    import rv_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        instr_done,
    output logic        illegal
);

    mc_state_t  state;
    mc_state_t  next;
    logic [1:0] alu_op;
    logic [6:0] opcode;
    logic       unused_ins;

    assign opcode     = ins[6:0];
    assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next;
    end

    mc_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (ins[14:12]),
        .op5         (ins[5]),
        .funct7_5    (ins[30]),
        .alu_control (alu_control)
    );

    always_comb begin
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    always_comb begin
        next       = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALU_OP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_R:         next = S_EXECUTER;
                    OP_I:         next = S_EXECUTEI;
                    OP_JAL:       next = S_JAL;
                    OP_BEQ:       next = S_BEQ;
                    default: begin
                        next    = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                next      = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = mem_ready;
                instr_done = mem_ready;
                if (mem_ready) next = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_FUNCT;
                next      = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
                next      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next       = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                next      = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_OP_SUB;
                pc_write   = zero;
                instr_done = 1'b1;
                next       = S_FETCH;
            end
            default: next = S_FETCH;
        endcase
        // Async reset already forces FETCH; also kill its mem_ready-driven writes
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output
// vectors are queued with their stimulus and compared as the FSM steps.
module tb_multicycle_controller;

    localparam int S_F   = 0;
    localparam int S_D   = 1;
    localparam int S_MA  = 2;
    localparam int S_MR  = 3;
    localparam int S_MWB = 4;
    localparam int S_MW  = 5;
    localparam int S_ER  = 6;
    localparam int S_EI  = 7;
    localparam int S_AWB = 8;
    localparam int S_J   = 9;
    localparam int S_B   = 10;

    typedef struct {
        logic [31:0] ins;
        logic        mr;
        logic        z;
        logic [17:0] exp;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ins = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0]  alu_control;
    logic        instr_done, illegal;

    int   checks = 0;
    int   passed = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .ins         (ins),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    function automatic logic [17:0] obs();
        return {pc_write, adr_src, ir_write, mem_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src,
                alu_control, instr_done, illegal};
    endfunction

    function automatic logic [2:0] exp_alu(logic [31:0] i);
        case (i[14:12])
            3'b000:  return (i[5] & i[30]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] model(int st, logic [31:0] i,
                                          logic z, logic mr);
        logic       pcw, adr, irw, mw, rw, dn, il;
        logic [1:0] a, b, rs, im;
        logic [2:0] ac;
        logic [6:0] op;
        op = i[6:0];
        {pcw, adr, irw, mw, rw, dn, il} = 7'b0;
        a = 2'b00; b = 2'b00; rs = 2'b00; ac = 3'b000;
        case (op)
            7'h23:   im = 2'b01;
            7'h63:   im = 2'b10;
            7'h6F:   im = 2'b11;
            default: im = 2'b00;
        endcase
        case (st)
            S_F:   begin pcw = mr; irw = mr; b = 2'b10; rs = 2'b10; end
            S_D: begin
                a = 2'b01; b = 2'b01;
                il = !(op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63});
            end
            S_MA:  begin a = 2'b10; b = 2'b01; end
            S_MR:  adr = 1'b1;
            S_MWB: begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
            S_MW:  begin adr = 1'b1; mw = mr; dn = mr; end
            S_ER:  begin a = 2'b10; ac = exp_alu(i); end
            S_EI:  begin a = 2'b10; b = 2'b01; ac = exp_alu(i); end
            S_AWB: begin rw = 1'b1; dn = 1'b1; end
            S_J:   begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            S_B:   begin a = 2'b10; ac = 3'b001; pcw = z; dn = 1'b1; end
            default: ;
        endcase
        return {pcw, adr, irw, mw, rw, a, b, rs, im, ac, dn, il};
    endfunction

    task automatic push(int st, logic [31:0] i, logic mr, logic z);
        ent_t e;
        e.ins = i; e.mr = mr; e.z = z;
        e.exp = model(st, i, z, mr);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [17:0] e;
        reset = 1'b1; ins = 32'h00402283; mem_ready = 1'b1;
        e = model(S_F, ins, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== e)
                $display("FAIL reset cyc%0d got %b exp %b", k, obs(), e);
            else passed++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        ent_t e;
        int   n = 0;
        logic [31:0] i = 32'h00402283;
        push(S_F, i, 1, 0); push(S_D, i, 1, 0); push(S_MA, i, 1, 0);
        push(S_MR, i, 1, 0); push(S_MWB, i, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL lw cyc%0d got %b exp %b", n, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        ent_t e;
        int   n = 0;
        logic [31:0] i = 32'h0062A223;
        push(S_F, i, 1, 0); push(S_D, i, 0, 0); push(S_MA, i, 0, 0);
        push(S_MW, i, 0, 0); push(S_MW, i, 0, 0); push(S_MW, i, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL sw cyc%0d got %b exp %b", n, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_ops();
        ent_t e;
        int   n = 0;
        logic [31:0] rt [6] = '{32'h40628233, 32'h00628233, 32'h0062F233,
                                32'h0062E233, 32'h0062A233, 32'h00629233};
        logic [31:0] it [2] = '{32'h00500293, 32'h40028293};
        foreach (rt[k]) begin
            push(S_F, rt[k], 1, 0); push(S_D, rt[k], 1, 0);
            push(S_ER, rt[k], 1, 0); push(S_AWB, rt[k], 1, 0);
        end
        foreach (it[k]) begin
            push(S_F, it[k], 1, 0); push(S_D, it[k], 1, 0);
            push(S_EI, it[k], 1, 0); push(S_AWB, it[k], 1, 0);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL alu cyc%0d ins %h got %b exp %b",
                         n, e.ins, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        ent_t e;
        int   n = 0;
        logic [31:0] i = 32'h00628463;
        push(S_F, i, 1, 0); push(S_D, i, 1, 1); push(S_B, i, 1, 1);
        push(S_F, i, 1, 1); push(S_D, i, 1, 0); push(S_B, i, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL beq cyc%0d got %b exp %b", n, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal_illegal();
        ent_t e;
        int   n = 0;
        logic [31:0] j = 32'h008000EF;
        logic [31:0] x = 32'h0000007F;
        push(S_F, j, 1, 0); push(S_D, j, 0, 0); push(S_J, j, 0, 0);
        push(S_AWB, j, 0, 0);
        push(S_F, x, 1, 0); push(S_D, x, 1, 0); push(S_F, x, 0, 0);
        push(S_F, x, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL jal_ill cyc%0d got %b exp %b", n, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int   n = 0;
        logic [31:0] l = 32'h00402283;
        logic [31:0] b = 32'h00628463;
        push(S_F, b, 1, 0); push(S_D, l, 1, 0); push(S_MA, l, 1, 0);
        push(S_MR, l, 0, 0); push(S_MR, l, 1, 0); push(S_MWB, l, 1, 0);
        push(S_F, l, 0, 0); push(S_F, l, 1, 0);
        push(S_D, b, 1, 1); push(S_B, b, 1, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL b2b cyc%0d got %b exp %b", n, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        ent_t e;
        int   n = 0;
        logic [31:0] i = 32'h0062A223;
        logic [17:0] rexp;
        push(S_F, i, 1, 0); push(S_D, i, 1, 0); push(S_MA, i, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL abort_pre cyc%0d got %b exp %b", n, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        reset = 1'b1;
        rexp = model(S_F, i, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (obs() !== rexp)
                $display("FAIL abort_rst step%0d got %b exp %b", k, obs(), rexp);
            else passed++;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        push(S_F, i, 1, 0); push(S_D, i, 1, 0); push(S_MA, i, 1, 0);
        push(S_MW, i, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ins = e.ins; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs() !== e.exp)
                $display("FAIL abort_post cyc%0d got %b exp %b", n, obs(), e.exp);
            else passed++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_ops();
        test_beq();
        test_jal_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
